// File: rtl/alu_mem_subsystem.sv
// rtl/alu_mem_subsystem.sv - 64-bit ALU, reset-clearable data memory and fixed instruction ROM
module alu_mem_subsystem #(
  parameter int DMEM_WORDS = 32,
  parameter int IMEM_WORDS = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  ALUCtrl,
  input  logic [63:0] BusA,
  input  logic [63:0] BusB,
  output logic [63:0] BusW,
  output logic        Zero,
  input  logic [63:0] DAddress,
  input  logic [63:0] WriteData,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  output logic [63:0] ReadData,
  input  logic [63:0] IAddress,
  output logic [31:0] Instruction
);

  localparam int DAW = $clog2(DMEM_WORDS);
  localparam int IAW = $clog2(IMEM_WORDS);

  logic [63:0]    alu_w_d;
  logic [63:0]    mem_q [DMEM_WORDS];
  logic [DAW-1:0] dmem_idx;
  logic [IAW-1:0] rom_idx;
  logic           unused_addr_bits;

  // Doubleword and word indices; low alignment bits and high bits are dropped so addresses wrap
  assign dmem_idx = DAddress[DAW+2:3];
  assign rom_idx  = IAddress[IAW+1:2];
  assign unused_addr_bits = ^{DAddress[63:DAW+3], DAddress[2:0], IAddress[63:IAW+2], IAddress[1:0]};

  // ALU operation decode; unknown codes give zero so Zero asserts
  always_comb begin
    alu_w_d = 64'd0;
    case (ALUCtrl)
      4'b0000: alu_w_d = BusA & BusB;
      4'b0001: alu_w_d = BusA | BusB;
      4'b0010: alu_w_d = BusA + BusB;
      4'b0110: alu_w_d = BusA - BusB;
      4'b0111: alu_w_d = BusB;
      default: alu_w_d = 64'd0;
    endcase
  end

  assign BusW = alu_w_d;
  assign Zero = (alu_w_d == 64'd0);

  // Data memory: reset clears every doubleword at once and blocks the coincident write
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (MemoryWrite) begin
      mem_q[dmem_idx] <= WriteData;
    end
  end

  // Combinational load with no write bypass: the new value appears only after the edge
  assign ReadData = MemoryRead ? mem_q[dmem_idx] : 64'd0;

  // Fixed instruction ROM contents
  always_comb begin
    Instruction = 32'h0000_0000;
    case (rom_idx)
      IAW'(0): Instruction = 32'hF840_03E9;
      IAW'(1): Instruction = 32'hF840_83EA;
      IAW'(2): Instruction = 32'hF841_03EB;
      IAW'(3): Instruction = 32'hF841_83EC;
      default: Instruction = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_alu_mem_subsystem.sv
// tb/tb_alu_mem_subsystem.sv - directed self-checking bench for alu_mem_subsystem
module tb_alu_mem_subsystem;

  localparam int DMEM_WORDS = 32;
  localparam int IMEM_WORDS = 64;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ALUCtrl = 4'b0;
  logic [63:0] BusA = '0;
  logic [63:0] BusB = '0;
  logic [63:0] BusW;
  logic        Zero;
  logic [63:0] DAddress = '0;
  logic [63:0] WriteData = '0;
  logic        MemoryRead = 1'b0;
  logic        MemoryWrite = 1'b0;
  logic [63:0] ReadData;
  logic [63:0] IAddress = '0;
  logic [31:0] Instruction;

  int checks = 0;
  int errors = 0;

  alu_mem_subsystem #(.DMEM_WORDS(DMEM_WORDS), .IMEM_WORDS(IMEM_WORDS)) dut (
    .CLK(CLK), .reset(reset), .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB),
    .BusW(BusW), .Zero(Zero), .DAddress(DAddress), .WriteData(WriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .ReadData(ReadData),
    .IAddress(IAddress), .Instruction(Instruction)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
    logic        z;
  } alu_vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
  } rom_vec_t;

  alu_vec_t alu_tab [10];
  rom_vec_t rom_tab [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_check(input string name, input logic [63:0] addr, input logic [63:0] exp);
    DAddress = addr;
    MemoryRead = 1'b1;
    #1;
    check(name, ReadData, exp);
  endtask

  initial begin
    alu_tab[0] = '{4'b0010, 64'h5, 64'h3, 64'h8, 1'b0};
    alu_tab[1] = '{4'b0110, 64'h5, 64'h3, 64'h2, 1'b0};
    alu_tab[2] = '{4'b0000, 64'h5, 64'h3, 64'h1, 1'b0};
    alu_tab[3] = '{4'b0001, 64'h5, 64'h3, 64'h7, 1'b0};
    alu_tab[4] = '{4'b0111, 64'h5, 64'h3, 64'h3, 1'b0};
    alu_tab[5] = '{4'b0110, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    alu_tab[6] = '{4'b0110, 64'hA, 64'hA, 64'h0, 1'b1};
    alu_tab[7] = '{4'b1111, 64'h5, 64'h3, 64'h0, 1'b1};
    alu_tab[8] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 1'b0};
    alu_tab[9] = '{4'b0111, 64'h5, 64'h0, 64'h0, 1'b1};

    rom_tab[0] = '{64'd0,              32'hF84003E9};
    rom_tab[1] = '{64'd4,              32'hF84083EA};
    rom_tab[2] = '{64'd8,              32'hF84103EB};
    rom_tab[3] = '{64'd12,             32'hF84183EC};
    rom_tab[4] = '{64'd5,              32'hF84083EA};
    rom_tab[5] = '{64'd16,             32'h00000000};
    rom_tab[6] = '{64'(4*IMEM_WORDS),  32'hF84003E9};
    rom_tab[7] = '{64'(4*IMEM_WORDS+12), 32'hF84183EC};

    // Reset state
    reset = 1'b1;
    #2;
    load_check("reset_read_0", 64'd0, 64'd0);
    load_check("reset_read_8", 64'd8, 64'd0);
    @(negedge CLK);
    reset = 1'b0;

    // ALU table
    for (int i = 0; i < 10; i++) begin
      ALUCtrl = alu_tab[i].ctrl;
      BusA = alu_tab[i].a;
      BusB = alu_tab[i].b;
      #1;
      check($sformatf("alu_w[%0d]", i), BusW, alu_tab[i].w);
      check($sformatf("alu_z[%0d]", i), 64'(Zero), 64'(alu_tab[i].z));
    end

    // ROM table
    for (int i = 0; i < 8; i++) begin
      IAddress = rom_tab[i].addr;
      #1;
      check($sformatf("rom[%0d]", i), 64'(Instruction), 64'(rom_tab[i].instr));
    end

    // Store then load, with alias and wrap addresses
    @(negedge CLK);
    MemoryRead = 1'b0;
    DAddress = 64'd8;
    WriteData = 64'hDEADBEEF_00C0FFEE;
    MemoryWrite = 1'b1;
    @(posedge CLK);
    #1;
    MemoryWrite = 1'b0;
    load_check("load_8", 64'd8, 64'hDEADBEEF_00C0FFEE);
    load_check("load_15", 64'd15, 64'hDEADBEEF_00C0FFEE);
    load_check("load_16", 64'd16, 64'd0);
    load_check("load_wrap", 64'(8 + 8*DMEM_WORDS), 64'hDEADBEEF_00C0FFEE);

    // Second location for the reset-clear check
    @(negedge CLK);
    DAddress = 64'd24;
    WriteData = 64'h1234_5678_9ABC_DEF0;
    MemoryWrite = 1'b1;
    @(posedge CLK);
    #1;
    MemoryWrite = 1'b0;
    load_check("load_24", 64'd24, 64'h1234_5678_9ABC_DEF0);

    // Simultaneous read/write: old before edge, new after
    @(negedge CLK);
    DAddress = 64'd8;
    MemoryRead = 1'b1;
    WriteData = 64'h0000_0000_0000_0042;
    MemoryWrite = 1'b1;
    #1;
    check("rw_before_edge", ReadData, 64'hDEADBEEF_00C0FFEE);
    @(posedge CLK);
    #1;
    MemoryWrite = 1'b0;
    check("rw_after_edge", ReadData, 64'h42);

    // Write gating
    @(negedge CLK);
    WriteData = 64'hFFFF_0000_FFFF_0000;
    @(posedge CLK);
    #1;
    check("no_write_kept", ReadData, 64'h42);
    MemoryRead = 1'b0;
    #1;
    check("read_disabled", ReadData, 64'd0);

    // Async reset between edges, write attempted while held
    @(negedge CLK);
    MemoryRead = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("async_clear_8", ReadData, 64'd0);
    load_check("async_clear_24", 64'd24, 64'd0);
    DAddress = 64'd8;
    WriteData = 64'hAAAA_BBBB_CCCC_DDDD;
    MemoryWrite = 1'b1;
    @(posedge CLK);
    #1;
    check("write_in_reset", ReadData, 64'd0);
    @(negedge CLK);
    MemoryWrite = 1'b0;
    reset = 1'b0;
    #1;
    check("post_reset_zero", ReadData, 64'd0);

    // First write after deassertion is honoured
    @(negedge CLK);
    MemoryWrite = 1'b1;
    WriteData = 64'h5555_6666_7777_8888;
    @(posedge CLK);
    #1;
    MemoryWrite = 1'b0;
    check("first_write", ReadData, 64'h5555_6666_7777_8888);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
